// File: rtl/simon_seq_if.sv
// Round-sequence link between the Simon round generator (master) and the game FSM (slave).
// Handshake: en is a one-cycle pop strobe that consumes the head only while valid is high.
interface simon_seq_if #(
    parameter int DEPTH = 4
);
    logic                   en;
    logic                   seed_ld;
    logic [15:0]            seed;
    logic [11:0]            idx;
    logic                   lsb;
    logic                   valid;
    logic [$clog2(DEPTH):0] count;
    logic                   underflow;

    modport master (
        input  en, seed_ld, seed,
        output idx, lsb, valid, count, underflow
    );

    modport slave (
        output en, seed_ld, seed,
        input  idx, lsb, valid, count, underflow
    );
endinterface

// File: rtl/simon_seq_gen.sv
// Simon round generator: Galois LFSR feeding a show-ahead FIFO of rounds with distinct digits.
// Optional macro SIMON_SAYS_BIAS_EN raises the "Simon says" flag probability to ~75%.
module simon_seq_gen #(
    parameter int          DEPTH = 4,
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter logic [15:0] TAPS  = 16'hB400
) (
    input  logic        clk,
    input  logic        rst,
    simon_seq_if.master sq,
    output logic        dbg_state
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [15:0]   lfsr;
    logic [12:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          underflow;
    logic          cand_flag, cand_ok;
    logic          step, push, pop;

    // Candidate round is taken from the LFSR value before this cycle's step.
    always_comb begin
`ifdef SIMON_SAYS_BIAS_EN
        cand_flag = lfsr[12] | lfsr[13];
`else
        cand_flag = lfsr[12];
`endif
        cand_ok = (lfsr[3:0] != lfsr[7:4]) && (lfsr[3:0] != lfsr[11:8]) &&
                  (lfsr[7:4] != lfsr[11:8]);
        step    = (state == FILL);
        pop     = sq.en && !sq.seed_ld && (count != '0);
        push    = step && cand_ok && !sq.seed_ld && (count != CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (sq.seed_ld) begin
            state_nxt = FILL;
        end else begin
            case (state)
                FILL:    if (push && !pop && count == CW'(DEPTH - 1)) state_nxt = FULL;
                FULL:    if (pop) state_nxt = FILL;
                default: state_nxt = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr      <= SEED;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            underflow <= 1'b0;
        end else if (sq.seed_ld) begin
            lfsr      <= (sq.seed == 16'h0) ? SEED : sq.seed;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            if (step) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
            if (sq.en && count == '0) underflow <= 1'b1;
        end
    end

    // Entry storage needs no reset: valid gates everything read from it.
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= {lfsr[11:0], cand_flag};
    end

    always_comb begin
        sq.valid       = (count != '0);
        sq.count       = count;
        sq.underflow   = underflow;
        {sq.idx, sq.lsb} = (count != '0) ? mem[rd_ptr] : 13'h0;
        dbg_state      = (state == FULL);
    end
endmodule

// File: tb/tb_simon_seq_gen.sv
// Self-checking bench for simon_seq_gen: directed scenarios plus random traffic against a
// queue-based round model.
module tb_simon_seq_gen;
    localparam int          DEPTH = 4;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam logic [15:0] TAPS  = 16'hB400;

    logic clk = 1'b0;
    logic rst;
    logic dbg_state;

    simon_seq_if #(.DEPTH(DEPTH)) sq ();

    simon_seq_gen #(.DEPTH(DEPTH), .SEED(SEED), .TAPS(TAPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .sq        (sq),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: current LFSR value, queue of {digits, flag}, full flag, sticky underflow.
    logic [15:0] m_lfsr;
    logic [12:0] m_q[$];
    bit          m_full;
    bit          m_under;

    logic [17:0] obs_vec;
    assign obs_vec = {sq.idx, sq.lsb, sq.valid, sq.count, sq.underflow};

    logic [11:0] tbl_idx [4];
    logic        tbl_flag[4];

    function automatic bit distinct(input logic [11:0] d);
        int a, b, c;
        a = int'(d) % 16;
        b = (int'(d) / 16) % 16;
        c = int'(d) / 256;
        return (a != b) && (b != c) && (a != c);
    endfunction

    function automatic logic [15:0] next_lfsr(input logic [15:0] l);
        int v;
        v = int'(l);
        if (v % 2 == 1) return 16'(v / 2) ^ TAPS;
        return 16'(v / 2);
    endfunction

    function automatic logic [12:0] round_of(input logic [15:0] l);
        bit f;
`ifdef SIMON_SAYS_BIAS_EN
        f = l[12] || l[13];
`else
        f = l[12];
`endif
        return {l[11:0], f};
    endfunction

    function automatic logic [17:0] exp_vec();
        logic [12:0] h;
        h = (m_q.size() > 0) ? m_q[0] : 13'h0;
        return {h, m_q.size() > 0, 3'(m_q.size()), m_under};
    endfunction

    task automatic model_step(input bit r, input bit e, input bit s, input logic [15:0] sv);
        bit          popped, pushed;
        logic [12:0] cand;
        popped = 1'b0;
        pushed = 1'b0;
        cand   = '0;
        if (r) begin
            m_lfsr = SEED; m_q.delete(); m_full = 1'b0; m_under = 1'b0;
        end else if (s) begin
            m_lfsr = (sv == 16'h0) ? SEED : sv; m_q.delete(); m_full = 1'b0; m_under = 1'b0;
        end else begin
            popped = e && (m_q.size() > 0);
            if (e && m_q.size() == 0) m_under = 1'b1;
            if (!m_full) begin
                pushed = distinct(m_lfsr[11:0]);
                cand   = round_of(m_lfsr);
                m_lfsr = next_lfsr(m_lfsr);
            end
            if (popped) void'(m_q.pop_front());
            if (pushed) m_q.push_back(cand);
            if (popped) m_full = 1'b0;
            else if (pushed && m_q.size() == DEPTH) m_full = 1'b1;
        end
    endtask

    // Drive one cycle of inputs from the negedge, advance the model, land on the next negedge.
    task automatic cycle(input bit r, input bit e, input bit s, input logic [15:0] sv);
        rst        = r;
        sq.en      = e;
        sq.seed_ld = s;
        sq.seed    = sv;
        model_step(r, e, s, sv);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        vectors++;
        if (obs_vec !== 18'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h want=%h", obs_vec, 18'h0);
        end
        vectors++;
        if (dbg_state !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got=%b want=0", dbg_state);
        end
    endtask

    task automatic test_fill_order();
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 16'h0);
            vectors++;
            if (obs_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL fill_cycle%0d got=%h want=%h", i, obs_vec, exp_vec());
            end
        end
        vectors++;
        if (sq.count !== 3'd4 || dbg_state !== 1'b1 || sq.idx !== tbl_idx[0] ||
            sq.lsb !== tbl_flag[0]) begin
            miscompares++;
            $display("FAIL fill_full got count=%0d state=%b idx=%h lsb=%b want 4 1 %h %b",
                     sq.count, dbg_state, sq.idx, sq.lsb, tbl_idx[0], tbl_flag[0]);
        end
    endtask

    task automatic test_pop_full();
        logic [2:0] want_cnt[4];
        logic       want_en[4];
        want_cnt = '{3'd3, 3'd4, 3'd3, 3'd3};
        want_en  = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (i == 0) ? 1 : i;
            cycle(1'b0, want_en[i], 1'b0, 16'h0);
            vectors++;
            if (sq.idx !== tbl_idx[k] || sq.lsb !== tbl_flag[k] || sq.count !== want_cnt[i]) begin
                miscompares++;
                $display("FAIL pop_full_step%0d got idx=%h lsb=%b count=%0d want %h %b %0d",
                         i, sq.idx, sq.lsb, sq.count, tbl_idx[k], tbl_flag[k], want_cnt[i]);
            end
        end
    endtask

    task automatic test_reject();
        cycle(1'b0, 1'b0, 1'b1, 16'h01A1);
        vectors++;
        if (sq.count !== 3'd0 || sq.valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reject_load got count=%0d valid=%b want 0 0", sq.count, sq.valid);
        end
        cycle(1'b0, 1'b0, 1'b0, 16'h0);
        vectors++;
        if (sq.count !== 3'd0 || obs_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL reject_nopush got=%h want=%h", obs_vec, exp_vec());
        end
        cycle(1'b0, 1'b0, 1'b0, 16'h0);
        vectors++;
        if (sq.idx !== 12'h4D0 || sq.lsb !== 1'b1 || sq.count !== 3'd1) begin
            miscompares++;
            $display("FAIL reject_next got idx=%h lsb=%b count=%0d want 4d0 1 1",
                     sq.idx, sq.lsb, sq.count);
        end
    endtask

    task automatic test_en_every_cycle();
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 40; i++) begin
            if (sq.valid === 1'b1) begin
                vectors++;
                if (!distinct(sq.idx)) begin
                    miscompares++;
                    $display("FAIL every_distinct%0d got idx=%h want distinct digits", i, sq.idx);
                end
            end
            cycle(1'b0, 1'b1, 1'b0, 16'h0);
            vectors++;
            if (obs_vec !== exp_vec() || sq.underflow !== 1'b1 || sq.count > 3'd1) begin
                miscompares++;
                $display("FAIL every_cycle%0d got=%h want=%h", i, obs_vec, exp_vec());
            end
        end
    endtask

    task automatic test_seed_zero();
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 1'b0, 16'h0);
        vectors++;
        if (sq.count !== 3'd3 || sq.underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL seed0_pre got count=%0d uf=%b want 3 1", sq.count, sq.underflow);
        end
        cycle(1'b0, 1'b1, 1'b1, 16'h0);
        vectors++;
        if (sq.count !== 3'd0 || sq.valid !== 1'b0 || sq.underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL seed0_flush got count=%0d valid=%b uf=%b want 0 0 0",
                     sq.count, sq.valid, sq.underflow);
        end
        cycle(1'b0, 1'b0, 1'b0, 16'h0);
        vectors++;
        if (sq.idx !== tbl_idx[0] || sq.lsb !== tbl_flag[0] || sq.count !== 3'd1) begin
            miscompares++;
            $display("FAIL seed0_restart got idx=%h lsb=%b count=%0d want %h %b 1",
                     sq.idx, sq.lsb, sq.count, tbl_idx[0], tbl_flag[0]);
        end
    endtask

    task automatic test_rst_midrefill();
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 1'b0, 16'h0);
        cycle(1'b1, 1'b1, 1'b0, 16'h0);
        vectors++;
        if (obs_vec !== 18'h0 || dbg_state !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid got=%h state=%b want 0 0", obs_vec, dbg_state);
        end
        cycle(1'b0, 1'b0, 1'b0, 16'h0);
        vectors++;
        if (sq.idx !== tbl_idx[0] || sq.count !== 3'd1 || obs_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL rst_mid_restart got=%h want=%h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit          r, e, s;
            logic [15:0] sv;
            r  = ($urandom_range(0, 63) == 0);
            s  = ($urandom_range(0, 31) == 0);
            e  = ($urandom_range(0, 2) == 0);
            sv = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom());
            cycle(r, e, s, sv);
            vectors++;
            if (obs_vec !== exp_vec() || dbg_state !== m_full) begin
                miscompares++;
                $display("FAIL random%0d got=%h st=%b want=%h st=%b",
                         i, obs_vec, dbg_state, exp_vec(), m_full);
            end
        end
    endtask

    initial begin
        tbl_idx = '{12'hCE1, 12'h270, 12'h138, 12'h89C};
`ifdef SIMON_SAYS_BIAS_EN
        tbl_flag = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
        tbl_flag = '{1'b0, 1'b0, 1'b1, 1'b1};
`endif
        rst        = 1'b1;
        sq.en      = 1'b0;
        sq.seed_ld = 1'b0;
        sq.seed    = 16'h0;
        m_lfsr     = SEED;
        m_full     = 1'b0;
        m_under    = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill_order();
        test_pop_full();
        test_reject();
        test_en_every_cycle();
        test_seed_zero();
        test_rst_midrefill();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
